// File: rtl/battleship_matrix_scanner.sv
// battleship_matrix_scanner
// Row-scan display controller for the Battleship LED matrix. Holds one frame
// (ROWS words of BITS bits). Each row is shifted out MSB first, latched, and
// then driven for DWELL cycles. A new frame is taken only at a frame boundary,
// so the display never tears.
// Build option SCANNER_DBUF_EN: when defined, a pending buffer with a
// ready/valid handshake is used. When undefined, frame_in is sampled
// directly at each frame boundary and again on leaving IDLE.
module battleship_matrix_scanner #(
    parameter int ROWS    = 8,
    parameter int BITS    = 24,
    parameter int CLK_DIV = 4,
    parameter int DWELL   = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [ROWS*BITS-1:0] frame_in,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic                 ser_data,
    output logic                 ser_clk,
    output logic                 ser_latch,
    output logic [ROWS-1:0]      row_sel,
    output logic                 oe_n,
    output logic                 frame_done
);

    localparam int ROW_W = (ROWS    > 1) ? $clog2(ROWS)    : 1;
    localparam int BIT_W = (BITS    > 1) ? $clog2(BITS)    : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DWL_W = (DWELL   > 1) ? $clog2(DWELL)   : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DWELL
    } state_t;

    state_t               state, nxt_state;
    logic [ROW_W-1:0]     row, nxt_row;
    logic [DIV_W-1:0]     div_cnt, nxt_div_cnt;
    logic [BIT_W-1:0]     bit_cnt, nxt_bit_cnt;
    logic [DWL_W-1:0]     dwell_cnt, nxt_dwell_cnt;
    logic [BITS-1:0]      shreg, nxt_shreg;
    logic [ROWS*BITS-1:0] active;
    logic [BITS-1:0]      active_row;
    logic                 nxt_ser_clk;
    logic                 nxt_ser_latch;
    logic                 nxt_oe_n;
    logic                 nxt_frame_done;
    logic [ROWS-1:0]      nxt_row_sel;
    logic                 lit;
    logic                 boundary;
    logic                 idle_exit;

    assign active_row = active[int'(row)*BITS +: BITS];

    // The serial data pin is the MSB of the shift register. It is therefore
    // registered, and it reads 0 whenever nothing is being shifted.
    assign ser_data = shreg[BITS-1];

    // Next-state, counter and registered-output decode for the scan sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. This
        // way no path leaves a signal unassigned, and no latch is inferred.
        nxt_state     = state;
        nxt_row       = row;
        nxt_div_cnt   = div_cnt;
        nxt_bit_cnt   = bit_cnt;
        nxt_dwell_cnt = dwell_cnt;
        nxt_shreg     = shreg;
        nxt_ser_clk   = 1'b0;
        boundary      = 1'b0;
        idle_exit     = 1'b0;

        if (!enable) begin
            nxt_state     = S_IDLE;
            nxt_row       = '0;
            nxt_div_cnt   = '0;
            nxt_bit_cnt   = '0;
            nxt_dwell_cnt = '0;
            nxt_shreg     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    nxt_state = S_LOAD;
                    nxt_row   = '0;
                    idle_exit = 1'b1;
                end
                S_LOAD: begin
                    nxt_state   = S_SHIFT;
                    nxt_shreg   = active_row;
                    nxt_div_cnt = '0;
                    nxt_bit_cnt = '0;
                end
                S_SHIFT: begin
                    nxt_ser_clk = ser_clk;
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        nxt_div_cnt = '0;
                        if (!ser_clk) begin
                            nxt_ser_clk = 1'b1;
                        end else begin
                            // The falling half ends the bit. Advance to the next bit.
                            nxt_ser_clk = 1'b0;
                            nxt_shreg   = shreg << 1;
                            if (bit_cnt == BIT_W'(BITS - 1)) begin
                                nxt_state = S_LATCH;
                            end else begin
                                nxt_bit_cnt = bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        nxt_div_cnt = div_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    nxt_state     = S_DWELL;
                    nxt_dwell_cnt = '0;
                end
                S_DWELL: begin
                    if (dwell_cnt == DWL_W'(DWELL - 1)) begin
                        nxt_state = S_LOAD;
                        if (row == ROW_W'(ROWS - 1)) begin
                            nxt_row  = '0;
                            boundary = 1'b1;
                        end else begin
                            nxt_row = row + 1'b1;
                        end
                    end else begin
                        nxt_dwell_cnt = dwell_cnt + 1'b1;
                    end
                end
                default: nxt_state = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state, so that they line up with
        // the state once it is registered.
        lit            = (nxt_state == S_DWELL);
        nxt_ser_latch  = (nxt_state == S_LATCH);
        nxt_oe_n       = !lit;
        nxt_row_sel    = '0;
        if (lit) begin
            nxt_row_sel[nxt_row] = 1'b1;
        end
        nxt_frame_done = lit && (nxt_dwell_cnt == DWL_W'(DWELL - 1))
                             && (nxt_row == ROW_W'(ROWS - 1));
    end

    // State register, scan counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            row        <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            dwell_cnt  <= '0;
            shreg      <= '0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
            row_sel    <= '0;
            oe_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. Every
            // register then samples pre-edge values, and the order of the
            // statements cannot change the result.
            state      <= nxt_state;
            row        <= nxt_row;
            div_cnt    <= nxt_div_cnt;
            bit_cnt    <= nxt_bit_cnt;
            dwell_cnt  <= nxt_dwell_cnt;
            shreg      <= nxt_shreg;
            ser_clk    <= nxt_ser_clk;
            ser_latch  <= nxt_ser_latch;
            row_sel    <= nxt_row_sel;
            oe_n       <= nxt_oe_n;
            frame_done <= nxt_frame_done;
        end
    end

`ifdef SCANNER_DBUF_EN
    logic [ROWS*BITS-1:0] pending;
    logic                 unused_idle_exit;

    assign unused_idle_exit = idle_exit;

    // Double buffer. frame_ready is the inverse of the pending flag. A swap
    // needs the pending flag to be set, and an accept needs it to be clear,
    // so the two can never happen on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the frame buffers are reset on purpose. Until the first
            // swap, a blank frame must be scanned.
            active      <= '0;
            pending     <= '0;
            frame_ready <= 1'b1;
        end else if (boundary && !frame_ready) begin
            active      <= pending;
            frame_ready <= 1'b1;
        end else if (frame_valid && frame_ready) begin
            pending     <= frame_in;
            frame_ready <= 1'b0;
        end
    end
`else
    logic unused_frame_valid;

    assign unused_frame_valid = frame_valid;
    assign frame_ready        = 1'b1;

    // Single buffer. frame_in is taken only at a frame boundary or on leaving
    // IDLE. Changes to frame_in in the middle of a frame are therefore ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the frame buffer is reset on purpose. Until the first
            // sample, a blank frame must be scanned.
            active <= '0;
        end else if (boundary || idle_exit) begin
            active <= frame_in;
        end
    end
`endif

endmodule

// File: tb/tb_battleship_matrix_scanner.sv
// tb_battleship_matrix_scanner
// Randomized bench for battleship_matrix_scanner with CLK_DIV=1 and DWELL=4
// (row period 54 cycles). A frame-level reference model tracks the position
// inside the row period. From that position it derives every output with
// plain arithmetic.
module tb_battleship_matrix_scanner;

    localparam int ROWS = 8;
    localparam int BITS = 24;
    localparam int CD   = 1;
    localparam int DW   = 4;
    localparam int SH   = 2 * CD * BITS;   // shift cycles per row
    localparam int RP   = 2 + SH + DW;     // row period
    localparam int FP   = ROWS * RP;       // frame period
`ifdef SCANNER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif
    // {ser_data, ser_clk, ser_latch, row_sel, oe_n, frame_ready, frame_done}
    localparam logic [13:0] RST_OUTS = 14'b0_0_0_00000000_1_1_0;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic [ROWS*BITS-1:0] frame_in;
    logic                 frame_valid;
    logic                 frame_ready;
    logic                 ser_data;
    logic                 ser_clk;
    logic                 ser_latch;
    logic [ROWS-1:0]      row_sel;
    logic                 oe_n;
    logic                 frame_done;

    battleship_matrix_scanner #(
        .ROWS(ROWS), .BITS(BITS), .CLK_DIV(CD), .DWELL(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_in(frame_in),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch),
        .row_sel(row_sel), .oe_n(oe_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_done;

    // Reference model: scanning flag, position in the row period, row index,
    // and the active and pending frames.
    bit              m_busy;
    bit              m_pflag;
    int              m_t;
    int              m_row;
    logic [BITS-1:0] m_act  [ROWS];
    logic [BITS-1:0] m_pend [ROWS];

    // Serial word rebuilt from the ser_clk rising edges.
    logic [BITS-1:0] cap;
    int              nbits;
    logic            prev_sclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [ROWS*BITS-1:0] rand_frame();
        logic [ROWS*BITS-1:0] f;
        for (int r = 0; r < ROWS; r++) f[r*BITS +: BITS] = BITS'($urandom);
        return f;
    endfunction

    function automatic logic [13:0] dut_outs();
        return {ser_data, ser_clk, ser_latch, row_sel, oe_n, frame_ready, frame_done};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_pflag = 1'b0;
        m_t     = 0;
        m_row   = 0;
        for (int r = 0; r < ROWS; r++) begin
            m_act[r]  = '0;
            m_pend[r] = '0;
        end
    endtask

    task automatic take_frame();
        for (int r = 0; r < ROWS; r++) m_act[r] = frame_in[r*BITS +: BITS];
    endtask

    // Advance the model by one clock edge, using the inputs seen at that edge.
    task automatic model_step();
        bit at_end;
`ifdef SCANNER_DBUF_EN
        bit acc;
        acc = frame_valid && !m_pflag;
`endif
        at_end = 1'b0;
        if (!enable) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_row  = 0;
        end else if (!m_busy) begin
            m_busy = 1'b1;
            m_t    = 0;
            m_row  = 0;
`ifndef SCANNER_DBUF_EN
            take_frame();
`endif
        end else if (m_t == RP - 1) begin
            m_t = 0;
            if (m_row == ROWS - 1) begin
                m_row  = 0;
                at_end = 1'b1;
            end else begin
                m_row++;
            end
        end else begin
            m_t++;
        end
`ifdef SCANNER_DBUF_EN
        if (at_end && m_pflag) begin
            m_act   = m_pend;
            m_pflag = 1'b0;
        end
        if (acc) begin
            for (int r = 0; r < ROWS; r++) m_pend[r] = frame_in[r*BITS +: BITS];
            m_pflag = 1'b1;
        end
`else
        if (at_end) take_frame();
`endif
    endtask

    // Expected outputs for the current model position.
    // t = 0: LOAD. t = 1..SH: SHIFT. t = SH+1: LATCH. After that: DWELL.
    function automatic logic [13:0] model_outs();
        logic            sd, sc, sl, oe, rd, fd;
        logic [ROWS-1:0] rs;
        logic [BITS-1:0] w;
        int              k;
        sd = 1'b0; sc = 1'b0; sl = 1'b0; oe = 1'b1; fd = 1'b0; rs = '0;
        if (m_busy) begin
            if (m_t >= 1 && m_t <= SH) begin
                k  = m_t - 1;
                w  = m_act[m_row];
                sc = ((k % (2 * CD)) >= CD);
                sd = w[BITS - 1 - k / (2 * CD)];
            end
            sl = (m_t == SH + 1);
            if (m_t >= SH + 2) begin
                rs = ROWS'(1) << m_row;
                oe = 1'b0;
            end
            fd = (m_row == ROWS - 1) && (m_t == RP - 1);
        end
        rd = DBUF ? !m_pflag : 1'b1;
        return {sd, sc, sl, rs, oe, rd, fd};
    endfunction

    // One clock cycle: step the model at the rising edge, then check at the
    // falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        cyc++;
        check("outs", dut_outs(), model_outs());
        if (ser_clk && !prev_sclk) begin
            cap = {cap[BITS-2:0], ser_data};
            nbits++;
        end
        prev_sclk = ser_clk;
        if (ser_latch) begin
            check("serial_bits", nbits, BITS);
            check("serial_word", cap, m_act[m_row]);
            nbits = 0;
        end
        if (!m_busy) nbits = 0;
        if (!enable) begin
            last_done = -1;
        end else if (frame_done) begin
            if (last_done >= 0) check("done_period", cyc - last_done, FP);
            last_done = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROWS*BITS-1:0] f;
        int waited;

        rst_n = 1'b0; enable = 1'b0; frame_valid = 1'b0; frame_in = '0;
        model_reset();
        nbits = 0; prev_sclk = 1'b0; cap = '0; last_done = -1;
        #7;
        check("reset_values", dut_outs(), RST_OUTS);

        // First frame, with row 0 = A5A5A5. Then two full frames so that the
        // rows wrap around.
        f = rand_frame();
        f[0 +: BITS] = 24'hA5A5A5;
        frame_in = f;
        frame_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1;
        tick();
        frame_valid = 1'b0;
        run(2 * FP + 60);

        // Asynchronous reset in the middle of DWELL.
        waited = 0;
        while (!(m_busy && m_t >= SH + 2) && waited < 2 * RP) begin
            tick();
            waited++;
        end
        check("reach_dwell", waited < 2 * RP, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", dut_outs(), RST_OUTS);
        model_reset();
        nbits = 0; prev_sclk = 1'b0; last_done = -1;
        frame_in = rand_frame();
        @(negedge clk);
        rst_n = 1'b1;
        run(100);

        // Handshake: frame A, then frame B held while the pending buffer is full.
        frame_in = rand_frame();
        frame_valid = 1'b1;
        tick();
        check("ready_after_a", frame_ready, DBUF ? 1'b0 : 1'b1);
        frame_in = rand_frame();
        waited = 0;
        while (!frame_ready && waited <= FP + 1) begin
            tick();
            waited++;
        end
        check("b_wait_timeout", waited <= FP + 1, 1);
        tick();
        frame_valid = 1'b0;
        check("ready_after_b", frame_ready, DBUF ? 1'b0 : 1'b1);
        run(FP + RP);

        // Drop enable during the SHIFT of row 3, then re-enable.
        waited = 0;
        while (!(m_busy && m_row == 3 && m_t >= 1 && m_t <= SH) && waited < 2 * FP) begin
            tick();
            waited++;
        end
        check("reach_row3_shift", waited < 2 * FP, 1);
        enable = 1'b0;
        tick();
        check("drop_oe_n", oe_n, 1'b1);
        check("drop_row_sel", row_sel, '0);
        enable = 1'b1;
        run(RP + 5);

        // Random phase: frame_in changes in the middle of frames, frame_valid
        // is random, and enable drops now and then.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) frame_in = rand_frame();
            frame_valid = ($urandom_range(0, 2) == 0);
            if (enable && $urandom_range(0, 599) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
